sobel_stream_core: RTL and testbench

- Synthesizable streaming 3x3 Sobel engine.
- Takes one raster-order pixel stream per frame and produces Gx, Gy, |Gx|+|Gy| and a thresholded edge flag for every pixel.
- Borders use replicate padding on all four sides.
- Sits between the pixel source (file or DMA reader) and the gradient writer, replacing the row-shuffling harness plus two combinational MAC instances.

---
 rtl/sobel_pkg.sv | 18 +
 rtl/sobel_line_buffer.sv | 48 ++++
 rtl/sobel_stream_core.sv | 242 ++++++++++++++++++++++++
 tb/tb_sobel_stream_core.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the streaming 3x3 Sobel engine.
package sobel_pkg;

   typedef enum logic [1:0] {FILL, RUN, EOL, FLUSH} state_t;

   // Mask rows are ordered top, middle, bottom; columns left, centre, right.
   localparam int K_GX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
   localparam int K_GY [3][3] = '{'{ 1, 2, 1}, '{ 0, 0, 0}, '{-1, -2, -1}};

   function automatic int calc_g_w(input int pix_w);
      return pix_w + 3;
   endfunction

   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Two-row line store for the Sobel window; the oldest row is overwritten as the new row arrives.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int IMG_W = 256,
   parameter int PIX_W = 8,
   localparam int AW = addr_w(IMG_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    rd_addr,
   input  logic             wr_en,
   input  logic             wr_both,
   input  logic [AW-1:0]    wr_addr,
   input  logic [PIX_W-1:0] wr_data,
   input  logic             rotate,
   output logic [PIX_W-1:0] rd_top,
   output logic [PIX_W-1:0] rd_mid
);

   logic [PIX_W-1:0] mem_a [IMG_W];
   logic [PIX_W-1:0] mem_b [IMG_W];
   logic [PIX_W-1:0] rd_a;
   logic [PIX_W-1:0] rd_b;
   logic             sel;
   logic             we_a;
   logic             we_b;

   // sel=0: bank A holds the older (top) row.
   assign we_a = wr_en && (wr_both || !sel);
   assign we_b = wr_en && (wr_both || sel);

   always_ff @(posedge clk) begin
      rd_a <= mem_a[rd_addr];
      rd_b <= mem_b[rd_addr];
      if (we_a) mem_a[wr_addr] <= wr_data;
      if (we_b) mem_b[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst)         sel <= 1'b0;
      else if (rotate) sel <= ~sel;
   end

   assign rd_top = sel ? rd_b : rd_a;
   assign rd_mid = sel ? rd_a : rd_b;

endmodule

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel core: raster pixels in, Gx/Gy/magnitude/edge out with replicate padding.
module sobel_stream_core
   import sobel_pkg::*;
#(
   parameter int IMG_W = 256,
   parameter int IMG_H = 256,
   parameter int PIX_W = 8,
   localparam int G_W = calc_g_w(PIX_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [PIX_W-1:0] s_data,
   input  logic [G_W-1:0]   thresh,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [G_W-1:0]   m_gx,
   output logic [G_W-1:0]   m_gy,
   output logic [G_W-1:0]   m_mag,
   output logic             m_edge,
   output logic             m_eol,
   output logic             m_last
);

   localparam int AW = addr_w(IMG_W);
   localparam int RW = addr_w(IMG_H);

   state_t state, state_nxt;
   logic [AW-1:0] col, col_nxt;
   logic [RW-1:0] row;
   logic fl_eol, fl_done;
   logic col_last, row_last, ld_ok, s_ready_c;
   logic adv, emit, emit_eol, emit_last, lb_we, lb_both, rotate;
   logic row_inc, row_clr, fl_eol_set, fl_done_set;

   logic [PIX_W-1:0] lb_top, lb_mid;
   logic [PIX_W-1:0] p_col [3];
   logic [PIX_W-1:0] wl_p0 [3];
   logic [PIX_W-1:0] wc_p0 [3];
   logic [PIX_W-1:0] win [3][3];

   int acc_x, acc_y;
   logic signed [G_W-1:0] gx_c, gy_c;
   logic [G_W:0]          mag_sum;
   logic [G_W-1:0]        mag_c;

   logic                  vld_p1;
   logic signed [G_W-1:0] gx_p1, gy_p1;
   logic [G_W-1:0]        mag_p1;
   logic                  edge_p1, eol_p1, last_p1;

   function automatic logic [G_W-1:0] abs_g(input logic signed [G_W-1:0] v);
      return v[G_W-1] ? -v : v;
   endfunction

   function automatic logic [G_W-1:0] sat_mag(input logic [G_W:0] s);
      return s[G_W] ? {G_W{1'b1}} : s[G_W-1:0];
   endfunction

   assign col_last  = (col == AW'(IMG_W - 1));
   assign row_last  = (row == RW'(IMG_H - 1));
   assign ld_ok     = !vld_p1 || m_ready;
   assign s_ready   = s_ready_c && !rst;

   always_comb begin
      state_nxt   = state;
      s_ready_c   = 1'b0;
      adv         = 1'b0;
      emit        = 1'b0;
      emit_eol    = 1'b0;
      emit_last   = 1'b0;
      lb_we       = 1'b0;
      lb_both     = 1'b0;
      rotate      = 1'b0;
      row_inc     = 1'b0;
      row_clr     = 1'b0;
      fl_eol_set  = 1'b0;
      fl_done_set = 1'b0;
      unique case (state)
         FILL: begin
            // Row 0 goes into both banks so it also serves as the padded row -1.
            s_ready_c = 1'b1;
            if (s_valid) begin
               adv     = 1'b1;
               lb_we   = 1'b1;
               lb_both = 1'b1;
               if (col_last) begin
                  row_inc   = 1'b1;
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            s_ready_c = ld_ok;
            if (s_valid && ld_ok) begin
               adv   = 1'b1;
               lb_we = 1'b1;
               emit  = (col != '0);
               if (col_last) state_nxt = EOL;
            end
         end
         EOL: begin
            if (ld_ok) begin
               emit     = 1'b1;
               emit_eol = 1'b1;
               rotate   = 1'b1;
               if (row_last) begin
                  state_nxt = FLUSH;
               end else begin
                  row_inc   = 1'b1;
                  state_nxt = RUN;
               end
            end
         end
         FLUSH: begin
            // Final row replays the middle bank as its own bottom neighbour.
            if (fl_done) begin
               if (vld_p1 && m_ready && last_p1) begin
                  row_clr   = 1'b1;
                  state_nxt = FILL;
               end
            end else if (ld_ok) begin
               if (fl_eol) begin
                  emit        = 1'b1;
                  emit_eol    = 1'b1;
                  emit_last   = 1'b1;
                  fl_done_set = 1'b1;
               end else begin
                  adv        = 1'b1;
                  emit       = (col != '0);
                  fl_eol_set = col_last;
               end
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   assign col_nxt = adv ? (col_last ? '0 : col + AW'(1)) : col;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FILL;
         col     <= '0;
         row     <= '0;
         fl_eol  <= 1'b0;
         fl_done <= 1'b0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         if (row_clr)      row <= '0;
         else if (row_inc) row <= row + RW'(1);
         if (fl_done_set)     fl_eol <= 1'b0;
         else if (fl_eol_set) fl_eol <= 1'b1;
         if (row_clr)          fl_done <= 1'b0;
         else if (fl_done_set) fl_done <= 1'b1;
      end
   end

   sobel_line_buffer #(.IMG_W(IMG_W), .PIX_W(PIX_W)) u_lb (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (col_nxt),
      .wr_en   (lb_we),
      .wr_both (lb_both),
      .wr_addr (col),
      .wr_data (s_data),
      .rotate  (rotate),
      .rd_top  (lb_top),
      .rd_mid  (lb_mid)
   );

   // Stage p0: column window, left/centre registered, right is the incoming column.
   assign p_col[0] = lb_top;
   assign p_col[1] = lb_mid;
   assign p_col[2] = (state == FLUSH) ? lb_mid : s_data;

   always_ff @(posedge clk) begin
      if (adv) begin
         for (int i = 0; i < 3; i++) begin
            wl_p0[i] <= (col == '0) ? p_col[i] : wc_p0[i];
            wc_p0[i] <= p_col[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         win[i][0] = wl_p0[i];
         win[i][1] = wc_p0[i];
         win[i][2] = emit_eol ? wc_p0[i] : p_col[i];
      end
   end

   always_comb begin
      acc_x = 0;
      acc_y = 0;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            acc_x = acc_x + K_GX[i][j] * int'(win[i][j]);
            acc_y = acc_y + K_GY[i][j] * int'(win[i][j]);
         end
      end
      gx_c    = acc_x[G_W-1:0];
      gy_c    = acc_y[G_W-1:0];
      mag_sum = {1'b0, abs_g(gx_c)} + {1'b0, abs_g(gy_c)};
      mag_c   = sat_mag(mag_sum);
   end

   // Stage p1: output register, held while downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         gx_p1   <= '0;
         gy_p1   <= '0;
         mag_p1  <= '0;
         edge_p1 <= 1'b0;
         eol_p1  <= 1'b0;
         last_p1 <= 1'b0;
      end else if (emit) begin
         vld_p1  <= 1'b1;
         gx_p1   <= gx_c;
         gy_p1   <= gy_c;
         mag_p1  <= mag_c;
         edge_p1 <= (mag_c >= thresh);
         eol_p1  <= emit_eol;
         last_p1 <= emit_last;
      end else if (m_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign m_valid = vld_p1;
   assign m_gx    = gx_p1;
   assign m_gy    = gy_p1;
   assign m_mag   = mag_p1;
   assign m_edge  = edge_p1;
   assign m_eol   = eol_p1;
   assign m_last  = last_p1;

endmodule

// File: tb/tb_sobel_stream_core.sv
// Scoreboard bench for sobel_stream_core on a reduced 16x12 frame.
module tb_sobel_stream_core;

   localparam int W     = 16;
   localparam int H     = 12;
   localparam int PW    = 8;
   localparam int GW    = 11;
   localparam int LIMIT = 5000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, s_valid, s_ready, m_valid, m_ready, m_edge, m_eol, m_last;
   logic [PW-1:0] s_data;
   logic [GW-1:0] thresh, m_gx, m_gy, m_mag;

   sobel_stream_core #(.IMG_W(W), .IMG_H(H), .PIX_W(PW)) dut (
      .clk     (clk),
      .rst     (rst),
      .s_valid (s_valid),
      .s_ready (s_ready),
      .s_data  (s_data),
      .thresh  (thresh),
      .m_valid (m_valid),
      .m_ready (m_ready),
      .m_gx    (m_gx),
      .m_gy    (m_gy),
      .m_mag   (m_mag),
      .m_edge  (m_edge),
      .m_eol   (m_eol),
      .m_last  (m_last)
   );

   typedef struct packed {
      logic [GW-1:0] gx;
      logic [GW-1:0] gy;
      logic [GW-1:0] mag;
      logic          edg;
      logic          eol;
      logic          last;
   } out_t;

   typedef struct {
      out_t o;
      int   r;
      int   c;
   } exp_t;

   exp_t          exp_q[$];
   out_t          obs [H][W];
   logic [PW-1:0] img [H][W];
   int            n_cmp  = 0;
   int            n_fail = 0;

   function automatic int px(input int r, input int c);
      int rr, cc;
      rr = (r < 0) ? 0 : ((r >= H) ? H - 1 : r);
      cc = (c < 0) ? 0 : ((c >= W) ? W - 1 : c);
      return int'(img[rr][cc]);
   endfunction

   function automatic out_t golden(input int r, input int c, input logic [GW-1:0] th);
      int   gx, gy, ax, ay, mg;
      out_t o;
      gx = px(r-1, c+1) + 2*px(r, c+1) + px(r+1, c+1)
         - px(r-1, c-1) - 2*px(r, c-1) - px(r+1, c-1);
      gy = px(r-1, c-1) + 2*px(r-1, c) + px(r-1, c+1)
         - px(r+1, c-1) - 2*px(r+1, c) - px(r+1, c+1);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      mg = ax + ay;
      if (mg > (1 << GW) - 1) mg = (1 << GW) - 1;
      o.gx   = gx[GW-1:0];
      o.gy   = gy[GW-1:0];
      o.mag  = mg[GW-1:0];
      o.edg  = (mg >= int'(th));
      o.eol  = (c == W - 1);
      o.last = (r == H - 1) && (c == W - 1);
      return o;
   endfunction

   task automatic run_frame(input int gap_pct, input int rdy_pct, output int n_eol, output int n_last);
      exp_t e;
      n_eol  = 0;
      n_last = 0;
      for (int r = 0; r < H; r++)
         for (int c = 0; c < W; c++) begin
            e.o = golden(r, c, thresh);
            e.r = r;
            e.c = c;
            exp_q.push_back(e);
         end
      fork
         begin
            int wt;
            bit acc;
            for (int r = 0; r < H; r++)
               for (int c = 0; c < W; c++) begin
                  if ($urandom_range(99) < gap_pct) begin
                     s_valid = 1'b0;
                     repeat ($urandom_range(3, 1)) @(posedge clk);
                     #1;
                  end
                  s_data  = img[r][c];
                  s_valid = 1'b1;
                  acc = 1'b0;
                  wt  = 0;
                  while (!acc && wt < LIMIT) begin
                     @(negedge clk);
                     acc = s_ready;
                     @(posedge clk);
                     #1;
                     wt++;
                  end
               end
            s_valid = 1'b0;
         end
         begin
            int   cnt, cyc;
            bit   held;
            out_t hold_v, cur;
            exp_t ex;
            cnt  = 0;
            cyc  = 0;
            held = 1'b0;
            while (cnt < W*H && cyc < LIMIT) begin
               @(posedge clk);
               #1;
               m_ready = ($urandom_range(99) < rdy_pct);
               @(negedge clk);
               cyc++;
               cur = {m_gx, m_gy, m_mag, m_edge, m_eol, m_last};
               if (held) begin
                  n_cmp++;
                  if (!m_valid || cur !== hold_v) begin
                     n_fail++;
                     $display("FAIL stall_hold: got vld=%0b %h, required vld=1 %h", m_valid, cur, hold_v);
                  end
               end
               held = 1'b0;
               if (m_valid && !m_ready) begin
                  held   = 1'b1;
                  hold_v = cur;
               end else if (m_valid && m_ready) begin
                  n_cmp++;
                  if (exp_q.size() == 0) begin
                     n_fail++;
                     $display("FAIL extra_output: got %h, required none", cur);
                  end else begin
                     ex = exp_q.pop_front();
                     if (cur !== ex.o) begin
                        n_fail++;
                        $display("FAIL pixel r%0d c%0d: got gx=%0d gy=%0d mag=%0d e=%0b eol=%0b last=%0b, required gx=%0d gy=%0d mag=%0d e=%0b eol=%0b last=%0b",
                                 ex.r, ex.c, $signed(cur.gx), $signed(cur.gy), cur.mag, cur.edg, cur.eol, cur.last,
                                 $signed(ex.o.gx), $signed(ex.o.gy), ex.o.mag, ex.o.edg, ex.o.eol, ex.o.last);
                     end
                     obs[ex.r][ex.c] = cur;
                  end
                  cnt++;
                  n_eol  += int'(m_eol);
                  n_last += int'(m_last);
               end
            end
            n_cmp++;
            if (cnt < W*H) begin
               n_fail++;
               $display("FAIL frame_timeout: got %0d outputs, required %0d", cnt, W*H);
               exp_q.delete();
            end
            m_ready = 1'b1;
         end
      join
   endtask

   task automatic test_reset();
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b1; thresh = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (s_ready !== 1'b0) begin n_fail++; $display("FAIL reset_s_ready: got %b, required 0", s_ready); end
      n_cmp++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", m_valid); end
      n_cmp++;
      if ({m_gx, m_gy, m_mag, m_edge, m_eol, m_last} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got %h, required 0", {m_gx, m_gy, m_mag, m_edge, m_eol, m_last});
      end
      rst = 1'b0;
      #1;
      n_cmp++;
      if (s_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_s_ready: got %b, required 1", s_ready); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_constant();
      int ne, nl;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = 8'd2;
      thresh = 11'd1;
      run_frame(0, 100, ne, nl);
      n_cmp++;
      if (ne !== H) begin n_fail++; $display("FAIL const_eol_count: got %0d, required %0d", ne, H); end
      n_cmp++;
      if (nl !== 1) begin n_fail++; $display("FAIL const_last_count: got %0d, required 1", nl); end
      n_cmp++;
      if (obs[H/2][W/2] !== '0) begin n_fail++; $display("FAIL const_centre: got %h, required 0", obs[H/2][W/2]); end
   endtask

   task automatic test_vstep();
      int ne, nl;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (c < W/2) ? 8'd0 : 8'd100;
      thresh = 11'd200;
      run_frame(0, 100, ne, nl);
      for (int r = 0; r < H; r += 5) begin
         n_cmp++;
         if (obs[r][W/2-1].gx !== 11'd400 || obs[r][W/2].gx !== 11'd400) begin
            n_fail++;
            $display("FAIL vstep_gx r%0d: got %0d,%0d, required 400,400", r, obs[r][W/2-1].gx, obs[r][W/2].gx);
         end
         n_cmp++;
         if (obs[r][0].gx !== '0 || obs[r][W-1].gx !== '0 || obs[r][W/2].gy !== '0) begin
            n_fail++;
            $display("FAIL vstep_zero r%0d: got gx0=%0d gxW=%0d gy=%0d, required 0", r, obs[r][0].gx, obs[r][W-1].gx, obs[r][W/2].gy);
         end
         n_cmp++;
         if (obs[r][W/2].edg !== 1'b1 || obs[r][W/2-2].edg !== 1'b0) begin
            n_fail++;
            $display("FAIL vstep_edge r%0d: got %b,%b, required 1,0", r, obs[r][W/2].edg, obs[r][W/2-2].edg);
         end
      end
   endtask

   task automatic test_hstep();
      int ne, nl;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = (r < H/2) ? 8'd0 : 8'd100;
      thresh = 11'd200;
      run_frame(0, 100, ne, nl);
      for (int c = 0; c < W; c += 5) begin
         n_cmp++;
         if (obs[H/2-1][c].gy !== 11'h670 || obs[H/2][c].gy !== 11'h670) begin
            n_fail++;
            $display("FAIL hstep_gy c%0d: got %0d,%0d, required -400,-400", c,
                     $signed(obs[H/2-1][c].gy), $signed(obs[H/2][c].gy));
         end
         n_cmp++;
         if (obs[0][c].gy !== '0 || obs[H-1][c].gy !== '0) begin
            n_fail++;
            $display("FAIL hstep_pad c%0d: got %0d,%0d, required 0,0", c, $signed(obs[0][c].gy), $signed(obs[H-1][c].gy));
         end
      end
   endtask

   task automatic test_ramp();
      int ne, nl;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = PW'(10*r + c);
      thresh = 11'd44;
      run_frame(0, 100, ne, nl);
      n_cmp++;
      if (obs[0][0] !== {11'd4, 11'h7d8, 11'd44, 1'b1, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL ramp_corner: got gx=%0d gy=%0d mag=%0d e=%0b, required gx=4 gy=-40 mag=44 e=1",
                  $signed(obs[0][0].gx), $signed(obs[0][0].gy), obs[0][0].mag, obs[0][0].edg);
      end
   endtask

   task automatic test_stall();
      int ne, nl;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = PW'($urandom_range(255));
      thresh = 11'($urandom_range(600));
      run_frame(30, 50, ne, nl);
      n_cmp++;
      if (ne !== H || nl !== 1) begin
         n_fail++;
         $display("FAIL stall_flags: got eol=%0d last=%0d, required %0d,1", ne, nl, H);
      end
   endtask

   task automatic test_back_to_back();
      int ne, nl;
      for (int f = 0; f < 2; f++) begin
         for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = PW'($urandom_range(255));
         thresh = 11'd300;
         run_frame(0, 100, ne, nl);
         n_cmp++;
         if (nl !== 1) begin n_fail++; $display("FAIL b2b_last f%0d: got %0d, required 1", f, nl); end
      end
   endtask

   task automatic test_reset_mid();
      int  lasts, wt, ne, nl;
      bit  acc;
      lasts = 0;
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = PW'($urandom_range(255));
      m_ready = 1'b1;
      for (int k = 0; k < 6*W + 3; k++) begin
         s_data  = img[k / W][k % W];
         s_valid = 1'b1;
         acc = 1'b0;
         wt  = 0;
         while (!acc && wt < LIMIT) begin
            @(negedge clk);
            acc = s_ready;
            if (m_valid && m_last) lasts++;
            @(posedge clk);
            #1;
            wt++;
         end
      end
      s_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++;
      if (m_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_m_valid: got %b, required 0", m_valid); end
      repeat (4) begin
         @(negedge clk);
         if (m_valid && m_last) lasts++;
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (lasts !== 0) begin n_fail++; $display("FAIL midrst_old_last: got %0d, required 0", lasts); end
      for (int r = 0; r < H; r++) for (int c = 0; c < W; c++) img[r][c] = PW'($urandom_range(255));
      thresh = 11'd250;
      run_frame(0, 100, ne, nl);
      n_cmp++;
      if (nl !== 1) begin n_fail++; $display("FAIL midrst_fresh_last: got %0d, required 1", nl); end
   endtask

   initial begin
      test_reset();
      test_constant();
      test_vstep();
      test_hstep();
      test_ramp();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
